// File: rtl/sample_sdram_arbiter.sv
// sample_sdram_arbiter
//   Shares the single sample SDRAM port between the sample-bank download
//   writer (byte writes from the HPS loader) and the sample player's 16-bit
//   wave reads. One download byte is buffered, one SDRAM command is in flight
//   at a time, every command is guarded by a timeout, and a pending read can
//   only be passed over by a bounded number of write grants.
//
// Ports
//   clk_sys      system clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   dl_wr        download byte strobe (accepted only while dl_wait=0)
//   dl_addr      download byte address
//   dl_data      download byte
//   dl_wait      write buffer full, loader must hold off
//   rd_req       read request level, held until rd_ack
//   rd_addr      read byte address (bit 0 ignored)
//   rd_ack       one-cycle pulse, rd_data valid in the same cycle
//   rd_data      read word, held until the next rd_ack
//   sd_cmd       one-cycle command strobe to the SDRAM controller
//   sd_we        1=write, 0=read, valid with sd_cmd
//   sd_addr      command address (reads are word aligned)
//   sd_din       write byte
//   sd_dout      SDRAM read word, valid with sd_done
//   sd_done      one-cycle completion pulse from the controller
//   err_timeout  sticky flag: some command timed out
module sample_sdram_arbiter #(
  parameter int AW      = 25,
  parameter int TIMEOUT = 64,
  parameter int STARVE  = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [15:0]   rd_data,
  output logic          sd_cmd,
  output logic          sd_we,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  input  logic [15:0]   sd_dout,
  input  logic          sd_done,
  output logic          err_timeout
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          cur_write;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] starve_cnt;

  logic          rd_pending;
  logic          dl_accept;
  logic          wr_pending;
  logic          grant_rd;
  logic          grant_wr;
  logic [AW-1:0] wr_addr_now;
  logic [7:0]    wr_data_now;
  logic          unused_rd_addr0;

  assign unused_rd_addr0 = rd_addr[0];

  assign dl_wait = buf_valid;

  // The requester keeps rd_req high during the rd_ack cycle, which is also
  // the IDLE cycle after a read completes; masking it there stops the same
  // read from being granted twice.
  assign rd_pending = rd_req & ~rd_ack;

  // A byte arriving while the buffer is empty counts as a pending write in
  // the same cycle, so a loader reacting to dl_wait falling can keep the
  // port busy back-to-back instead of losing every IDLE slot to a read.
  assign dl_accept   = dl_wr & ~buf_valid;
  assign wr_pending  = buf_valid | dl_accept;
  assign wr_addr_now = buf_valid ? buf_addr : dl_addr;
  assign wr_data_now = buf_valid ? buf_data : dl_data;

  assign grant_rd = rd_pending & (~wr_pending | (starve_cnt == STARVE_MAX));
  assign grant_wr = wr_pending & ~grant_rd;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      cur_write   <= 1'b0;
      to_cnt      <= '0;
      starve_cnt  <= '0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      sd_cmd      <= 1'b0;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_din      <= '0;
      err_timeout <= 1'b0;
    end else begin
      sd_cmd <= 1'b0;
      rd_ack <= 1'b0;

      if (dl_accept) begin
        buf_valid <= 1'b1;
        buf_addr  <= dl_addr;
        buf_data  <= dl_data;
      end

      if (!rd_pending) begin
        starve_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            sd_we     <= 1'b1;
            sd_addr   <= wr_addr_now;
            sd_din    <= wr_data_now;
            cur_write <= 1'b1;
            state     <= ISSUE;
            if (rd_pending && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_rd) begin
            sd_we      <= 1'b0;
            sd_addr    <= {rd_addr[AW-1:1], 1'b0};
            cur_write  <= 1'b0;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          sd_cmd <= 1'b1;
          to_cnt <= '0;
          state  <= WAIT;
        end

        WAIT: begin
          if (sd_done) begin
            if (cur_write) begin
              buf_valid <= 1'b0;
            end else begin
              rd_data <= sd_dout;
              rd_ack  <= 1'b1;
            end
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            // An aborted write drops its byte; an aborted read simply
            // competes again from IDLE because rd_req is still held.
            err_timeout <= 1'b1;
            if (cur_write) begin
              buf_valid <= 1'b0;
            end
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_sdram_arbiter.sv
// tb_sample_sdram_arbiter
//   Directed testbench for sample_sdram_arbiter with hand-computed expected
//   values: reset state, single write, single read, read starvation limit,
//   command timeout with read reissue, ignored strobes, and async reset
//   in the middle of a write command.
module tb_sample_sdram_arbiter;

  logic        clk_sys;
  logic        reset_n;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        sd_cmd;
  logic        sd_we;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic [15:0] sd_dout;
  logic        sd_done;
  logic        err_timeout;

  int compCount;
  int errCount;

  sample_sdram_arbiter #(
    .AW(25),
    .TIMEOUT(64),
    .STARVE(8)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .dl_wr(dl_wr),
    .dl_addr(dl_addr),
    .dl_data(dl_data),
    .dl_wait(dl_wait),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .sd_cmd(sd_cmd),
    .sd_we(sd_we),
    .sd_addr(sd_addr),
    .sd_din(sd_din),
    .sd_dout(sd_dout),
    .sd_done(sd_done),
    .err_timeout(err_timeout)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives every DUT input at once.
  task automatic applyStimulus(input logic wr, input logic [24:0] waddr,
                               input logic [7:0] wdata, input logic rreq,
                               input logic [24:0] raddr, input logic done,
                               input logic [15:0] dout);
    dl_wr   = wr;
    dl_addr = waddr;
    dl_data = wdata;
    rd_req  = rreq;
    rd_addr = raddr;
    sd_done = done;
    sd_dout = dout;
  endtask

  // Advances to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One read from IDLE with the controller answering one cycle after sd_cmd.
  task automatic readWord(input string tag, input logic [24:0] addr,
                          input logic [24:0] exp_addr, input logic [15:0] dout);
    applyStimulus(1'b0, '0, '0, 1'b1, addr, 1'b0, '0);
    tick();
    checkOutput({tag, "_we"}, 32'(sd_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(sd_addr), 32'(exp_addr));
    tick();
    checkOutput({tag, "_cmd"}, 32'(sd_cmd), 32'd1);
    tick();
    checkOutput({tag, "_ack_early"}, 32'(rd_ack), 32'd0);
    sd_done = 1'b1;
    sd_dout = dout;
    tick();
    sd_done = 1'b0;
    checkOutput({tag, "_ack"}, 32'(rd_ack), 32'd1);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'(dout));
    tick();
    rd_req = 1'b0;
    checkOutput({tag, "_ack_once"}, 32'(rd_ack), 32'd0);
    tick();
    checkOutput({tag, "_no_dup_cmd"}, 32'(sd_cmd), 32'd0);
    checkOutput({tag, "_data_held"}, 32'(rd_data), 32'(dout));
  endtask

  int          cmdCount;
  int          ackCount;
  logic        prevCmd;
  logic        ackPrev;
  logic [24:0] nextAddr;
  logic        logWe [32];
  logic [24:0] logAddr [32];
  int          cmdSeen;

  initial begin
    compCount = 0;
    errCount  = 0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);

    // Reset state.
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_dl_wait", 32'(dl_wait), 32'd0);
    checkOutput("rst_sd_cmd", 32'(sd_cmd), 32'd0);
    checkOutput("rst_sd_addr", 32'(sd_addr), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();

    // Single download byte with sd_done two cycles after sd_cmd.
    applyStimulus(1'b1, 25'h10, 8'hA5, 1'b0, '0, 1'b0, '0);
    tick();
    dl_wr = 1'b0;
    checkOutput("wr_wait_on", 32'(dl_wait), 32'd1);
    checkOutput("wr_we", 32'(sd_we), 32'd1);
    checkOutput("wr_addr", 32'(sd_addr), 32'h10);
    checkOutput("wr_din", 32'(sd_din), 32'hA5);
    tick();
    checkOutput("wr_cmd", 32'(sd_cmd), 32'd1);
    tick();
    checkOutput("wr_cmd_pulse", 32'(sd_cmd), 32'd0);
    tick();
    sd_done = 1'b1;
    checkOutput("wr_wait_held", 32'(dl_wait), 32'd1);
    tick();
    sd_done = 1'b0;
    checkOutput("wr_wait_off", 32'(dl_wait), 32'd0);
    checkOutput("wr_no_ack", 32'(rd_ack), 32'd0);
    tick();

    // Single read, odd address is word aligned.
    readWord("rd", 25'h123, 25'h122, 16'hBEEF);

    // Continuous writes against a held read: eight writes, the read, writes again.
    cmdCount = 0;
    ackCount = 0;
    prevCmd  = 1'b0;
    ackPrev  = 1'b0;
    nextAddr = 25'h200;
    applyStimulus(1'b0, '0, '0, 1'b1, 25'h300, 1'b0, 16'h1234);
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (sd_cmd) begin
        if (cmdCount < 32) begin
          logWe[cmdCount]   = sd_we;
          logAddr[cmdCount] = sd_addr;
        end
        cmdCount++;
      end
      if (rd_ack) ackCount++;
      sd_done = prevCmd;
      prevCmd = sd_cmd;
      if (ackPrev) rd_req = 1'b0;
      ackPrev = rd_ack;
      if (!dl_wait && cmdCount < 11) begin
        dl_wr    = 1'b1;
        dl_addr  = nextAddr;
        dl_data  = nextAddr[7:0];
        nextAddr = nextAddr + 25'd1;
      end else begin
        dl_wr = 1'b0;
      end
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    checkOutput("starve_cmd_count_min", 32'(cmdCount >= 11), 32'd1);
    if (cmdCount >= 11) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("starve_w%0d_we", i), 32'(logWe[i]), 32'd1);
      end
      checkOutput("starve_w0_addr", 32'(logAddr[0]), 32'h200);
      checkOutput("starve_w7_addr", 32'(logAddr[7]), 32'h207);
      checkOutput("starve_rd_we", 32'(logWe[8]), 32'd0);
      checkOutput("starve_rd_addr", 32'(logAddr[8]), 32'h300);
      checkOutput("starve_resume_we", 32'(logWe[9]), 32'd1);
      checkOutput("starve_resume_addr", 32'(logAddr[9]), 32'h208);
      checkOutput("starve_resume2_we", 32'(logWe[10]), 32'd1);
    end
    checkOutput("starve_ack_count", 32'(ackCount), 32'd1);
    checkOutput("starve_rd_data", 32'(rd_data), 32'h1234);
    tick();

    // Read that never completes: abort 64 cycles after sd_cmd, then reissue.
    applyStimulus(1'b0, '0, '0, 1'b1, 25'h41, 1'b0, '0);
    tick();
    tick();
    checkOutput("to_cmd", 32'(sd_cmd), 32'd1);
    checkOutput("to_addr", 32'(sd_addr), 32'h40);
    ackCount = 0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (rd_ack) ackCount++;
    end
    checkOutput("to_err_before", 32'(err_timeout), 32'd0);
    tick();
    if (rd_ack) ackCount++;
    checkOutput("to_err_set", 32'(err_timeout), 32'd1);
    checkOutput("to_no_ack", 32'(ackCount), 32'd0);
    tick();
    checkOutput("to_reissue_gap", 32'(sd_cmd), 32'd0);
    tick();
    checkOutput("to_reissue_cmd", 32'(sd_cmd), 32'd1);
    checkOutput("to_reissue_we", 32'(sd_we), 32'd0);
    tick();
    sd_done = 1'b1;
    sd_dout = 16'h5A5A;
    tick();
    sd_done = 1'b0;
    checkOutput("to_reissue_ack", 32'(rd_ack), 32'd1);
    checkOutput("to_reissue_data", 32'(rd_data), 32'h5A5A);
    tick();
    rd_req = 1'b0;
    checkOutput("to_err_sticky", 32'(err_timeout), 32'd1);
    tick();

    // Byte offered while dl_wait=1 is dropped.
    applyStimulus(1'b1, 25'h30, 8'h11, 1'b0, '0, 1'b0, '0);
    tick();
    checkOutput("lost_wait", 32'(dl_wait), 32'd1);
    dl_addr = 25'h31;
    dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    checkOutput("lost_cmd", 32'(sd_cmd), 32'd1);
    checkOutput("lost_addr", 32'(sd_addr), 32'h30);
    checkOutput("lost_din", 32'(sd_din), 32'h11);
    tick();
    sd_done = 1'b1;
    tick();
    sd_done = 1'b0;
    cmdSeen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sd_cmd) cmdSeen++;
    end
    checkOutput("lost_no_second_cmd", 32'(cmdSeen), 32'd0);

    // Stray sd_done while IDLE is ignored.
    sd_done = 1'b1;
    sd_dout = 16'hDEAD;
    tick();
    sd_done = 1'b0;
    checkOutput("stray_no_ack", 32'(rd_ack), 32'd0);
    checkOutput("stray_data", 32'(rd_data), 32'h5A5A);
    tick();
    checkOutput("stray_no_cmd", 32'(sd_cmd), 32'd0);
    readWord("post_stray", 25'h456, 25'h456, 16'hC0DE);

    // Async reset during WAIT of a write.
    applyStimulus(1'b1, 25'h77, 8'h99, 1'b0, '0, 1'b0, '0);
    tick();
    dl_wr = 1'b0;
    tick();
    tick();
    checkOutput("arst_pre_wait", 32'(dl_wait), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_dl_wait", 32'(dl_wait), 32'd0);
    checkOutput("arst_sd_we", 32'(sd_we), 32'd0);
    checkOutput("arst_sd_addr", 32'(sd_addr), 32'd0);
    checkOutput("arst_sd_din", 32'(sd_din), 32'd0);
    checkOutput("arst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("arst_err", 32'(err_timeout), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    cmdSeen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sd_cmd) cmdSeen++;
    end
    checkOutput("arst_byte_discarded", 32'(cmdSeen), 32'd0);
    checkOutput("arst_wait_after", 32'(dl_wait), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
